// File: rtl/alu_seq_if.sv
//------------------------------------------------------------------------------
// alu_seq_if : op request / result interface of the sequential ALU
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_seq_if #(
  parameter int DATA_W = 8,
  parameter int RW     = 2
);
  logic              op_valid;
  logic              op_ready;
  logic [4:0]        op;
  logic [RW-1:0]     src_a;
  logic [RW-1:0]     src_b;
  logic [RW-1:0]     dst;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              flag_z;
  logic              flag_c;
  logic              flag_n;
  logic              flag_e;

  modport master (
    output op_valid, op, src_a, src_b, dst, in_data,
    input  op_ready, out_data, out_valid, flag_z, flag_c, flag_n, flag_e
  );

  modport slave (
    input  op_valid, op, src_a, src_b, dst, in_data,
    output op_ready, out_data, out_valid, flag_z, flag_c, flag_n, flag_e
  );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
//------------------------------------------------------------------------------
// alu_seq : register-file ALU with single-cycle ops and iterative MUL/DIV
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  localparam int RW    = $clog2(NREGS)
) (
  input  wire       clk,
  input  wire       rst,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(DATA_W);

  localparam logic [4:0] OP_NOP  = 5'd0,  OP_LD   = 5'd1,  OP_MOV  = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_SHL  = 5'd5;
  localparam logic [4:0] OP_SHR  = 5'd6,  OP_AND  = 5'd7,  OP_OR   = 5'd8;
  localparam logic [4:0] OP_XOR  = 5'd9,  OP_CMPE = 5'd10, OP_CMPL = 5'd11;
  localparam logic [4:0] OP_CMPG = 5'd12, OP_MUL  = 5'd13, OP_DIV  = 5'd14;
  localparam logic [4:0] OP_OE   = 5'd15, OP_OEHI = 5'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] p_hi;
  logic [DATA_W-1:0] p_lo;
  logic [DATA_W-1:0] m;
  logic [CW-1:0]     cnt;
  logic              is_div;
  logic [RW-1:0]     dst_q;

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W:0]   alu_wide;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_try;

  assign a             = regs[bus.src_a];
  assign b             = regs[bus.src_b];
  assign bus.op_ready  = (state == IDLE);

  // Top bit of alu_wide is the carry/borrow/shifted-out bit.
  always_comb begin
    alu_wide = '0;
    case (bus.op)
      OP_ADD:  alu_wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu_wide = {1'b0, a} - {1'b0, b};
      OP_SHL:  alu_wide = {a, 1'b0};
      OP_SHR:  alu_wide = {a[0], 1'b0, a[DATA_W-1:1]};
      OP_AND:  alu_wide = {1'b0, a & b};
      OP_OR:   alu_wide = {1'b0, a | b};
      OP_XOR:  alu_wide = {1'b0, a ^ b};
      default: alu_wide = '0;
    endcase
  end

  assign alu_res = alu_wide[DATA_W-1:0];
  assign alu_c   = alu_wide[DATA_W];

  // {p_hi,p_lo} is the product/multiplier pair or the remainder/quotient pair.
  assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : '0);
  assign div_try = {p_hi, p_lo[DATA_W-1]} - {1'b0, m};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      hi            <= '0;
      p_hi          <= '0;
      p_lo          <= '0;
      m             <= '0;
      cnt           <= '0;
      is_div        <= 1'b0;
      dst_q         <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.flag_z    <= 1'b0;
      bus.flag_c    <= 1'b0;
      bus.flag_n    <= 1'b0;
      bus.flag_e    <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            case (bus.op)
              OP_NOP: ;
              OP_LD:  regs[bus.dst] <= bus.in_data;
              OP_MOV: regs[bus.dst] <= a;
              OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR: begin
                regs[bus.dst] <= alu_res;
                bus.flag_z    <= (alu_res == '0);
                bus.flag_c    <= alu_c;
                bus.flag_n    <= alu_res[DATA_W-1];
                bus.flag_e    <= 1'b0;
              end
              OP_CMPE: bus.flag_z <= (a == b);
              OP_CMPL: bus.flag_z <= (a < b);
              OP_CMPG: bus.flag_z <= (a > b);
              OP_MUL: begin
                m      <= a;
                p_hi   <= '0;
                p_lo   <= b;
                is_div <= 1'b0;
                dst_q  <= bus.dst;
                cnt    <= CW'(DATA_W - 1);
                state  <= BUSY;
              end
              OP_DIV: begin
                if (b == '0) begin
                  regs[bus.dst] <= '1;
                  hi            <= a;
                  bus.flag_z    <= 1'b0;
                  bus.flag_c    <= 1'b0;
                  bus.flag_n    <= 1'b0;
                  bus.flag_e    <= 1'b1;
                end else begin
                  m      <= b;
                  p_hi   <= '0;
                  p_lo   <= a;
                  is_div <= 1'b1;
                  dst_q  <= bus.dst;
                  cnt    <= CW'(DATA_W - 1);
                  state  <= BUSY;
                end
              end
              OP_OE: begin
                bus.out_data  <= a;
                bus.out_valid <= 1'b1;
              end
              OP_OEHI: begin
                bus.out_data  <= hi;
                bus.out_valid <= 1'b1;
              end
              default: bus.flag_e <= 1'b1;
            endcase
          end
        end
        BUSY: begin
          if (is_div) begin
            // Restoring step: keep the trial difference only when it did not borrow.
            p_hi <= div_try[DATA_W] ? {p_hi[DATA_W-2:0], p_lo[DATA_W-1]}
                                    : div_try[DATA_W-1:0];
            p_lo <= {p_lo[DATA_W-2:0], ~div_try[DATA_W]};
          end else begin
            {p_hi, p_lo} <= {mul_sum, p_lo[DATA_W-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          regs[dst_q] <= p_lo;
          hi          <= p_hi;
          bus.flag_z  <= is_div ? (p_lo == '0) : ({p_hi, p_lo} == '0);
          bus.flag_c  <= !is_div && (p_hi != '0);
          bus.flag_n  <= !is_div && p_lo[DATA_W-1];
          bus.flag_e  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//------------------------------------------------------------------------------
// tb_alu_seq : scoreboard bench for alu_seq (DATA_W=8, NREGS=4)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;
  localparam int W  = 8;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.DATA_W(W), .RW(2)) bus ();
  alu_seq #(.DATA_W(W), .NREGS(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;

  logic [W-1:0] m_regs [NR];
  logic [W-1:0] m_hi;
  logic         m_z, m_c, m_n, m_e;
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_hi = '0;
    {m_z, m_c, m_n, m_e} = 4'b0;
  endtask

  // Reference behaviour applied at the accepting edge.
  task automatic model(input logic [4:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] d, input logic [W-1:0] data);
    logic [W-1:0]   a, b, r;
    logic           c;
    logic [2*W-1:0] p;
    a = m_regs[sa];
    b = m_regs[sb];
    r = '0;
    c = 1'b0;
    case (op)
      5'd0: ;
      5'd1: m_regs[d] = data;
      5'd2: m_regs[d] = a;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9: begin
        case (op)
          5'd3: begin p = a + b; r = p[W-1:0]; c = p[W]; end
          5'd4: begin r = a - b; c = (a < b); end
          5'd5: begin r = a << 1; c = a[W-1]; end
          5'd6: begin r = a >> 1; c = a[0]; end
          5'd7: r = a & b;
          5'd8: r = a | b;
          default: r = a ^ b;
        endcase
        m_regs[d] = r;
        m_z = (r == 0);
        m_c = c;
        m_n = r[W-1];
        m_e = 1'b0;
      end
      5'd10: m_z = (a == b);
      5'd11: m_z = (a < b);
      5'd12: m_z = (a > b);
      5'd13: begin
        p = a * b;
        m_regs[d] = p[W-1:0];
        m_hi = p[2*W-1:W];
        m_z = (p == 0);
        m_c = (m_hi != 0);
        m_n = p[W-1];
        m_e = 1'b0;
      end
      5'd14: begin
        if (b == 0) begin
          m_regs[d] = '1;
          m_hi = a;
          {m_z, m_c, m_n, m_e} = 4'b0001;
        end else begin
          m_regs[d] = a / b;
          m_hi = a % b;
          m_z = ((a / b) == 0);
          {m_c, m_n, m_e} = 3'b000;
        end
      end
      5'd15: exp_q.push_back(a);
      5'd16: exp_q.push_back(m_hi);
      default: m_e = 1'b1;
    endcase
  endtask

  task automatic drive(input logic [4:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] d, input logic [W-1:0] data);
    bus.op       = op;
    bus.src_a    = sa;
    bus.src_b    = sb;
    bus.dst      = d;
    bus.in_data  = data;
    bus.op_valid = 1'b1;
  endtask

  task automatic wait_ready(output int t);
    t = 0;
    while (!bus.op_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("ready timeout", {31'b0, bus.op_ready}, 32'd1);
  endtask

  // Called at a falling edge; returns at the falling edge where the ALU is ready again.
  task automatic issue(input logic [4:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] d, input logic [W-1:0] data);
    int           t;
    logic [W-1:0] bb;
    drive(op, sa, sb, d, data);
    wait_ready(t);
    bb = m_regs[sb];
    @(posedge clk);
    model(op, sa, sb, d, data);
    @(negedge clk);
    bus.op_valid = 1'b0;
    wait_ready(t);
    check("busy cycles", t, (op == 5'd13 || (op == 5'd14 && bb != 0)) ? W + 1 : 0);
    check("flags zcne", {bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_e}, {m_z, m_c, m_n, m_e});
  endtask

  always @(posedge clk) if (!rst && bus.op_valid && bus.op_ready) n_acc++;

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) check("unexpected out_valid", {31'b0, bus.out_valid}, 32'd0);
      else check("out_data", bus.out_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int acc0;
    bus.op_valid = 1'b0;
    drive(5'd0, 2'd0, 2'd0, 2'd0, '0);
    bus.op_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset out_data", bus.out_data, 0);
    check("reset out_valid", {31'b0, bus.out_valid}, 0);
    check("reset flags", {bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_e}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready after reset", {31'b0, bus.op_ready}, 1);

    // Add with carry out
    issue(5'd1, 0, 0, 0, 8'hF0);
    issue(5'd1, 0, 0, 1, 8'h20);
    issue(5'd3, 0, 1, 2, 0);
    issue(5'd15, 2, 0, 0, 0);

    // Subtract with borrow, then compare-less keeps C/N
    issue(5'd1, 0, 0, 0, 8'h05);
    issue(5'd1, 0, 0, 1, 8'h07);
    issue(5'd4, 0, 1, 3, 0);
    issue(5'd15, 3, 0, 0, 0);
    issue(5'd11, 0, 1, 0, 0);

    // Multiply
    issue(5'd1, 0, 0, 0, 8'h0F);
    issue(5'd1, 0, 0, 1, 8'h11);
    issue(5'd13, 0, 1, 2, 0);
    issue(5'd15, 2, 0, 0, 0);
    issue(5'd16, 0, 0, 0, 0);
    issue(5'd1, 0, 0, 0, 8'hFF);
    issue(5'd13, 0, 0, 3, 0);
    issue(5'd15, 3, 0, 0, 0);
    issue(5'd16, 0, 0, 0, 0);

    // Divide, including divide by zero
    issue(5'd1, 0, 0, 0, 8'h64);
    issue(5'd1, 0, 0, 1, 8'h07);
    issue(5'd14, 0, 1, 2, 0);
    issue(5'd15, 2, 0, 0, 0);
    issue(5'd16, 0, 0, 0, 0);
    issue(5'd1, 0, 0, 1, 8'h00);
    issue(5'd14, 0, 1, 3, 0);
    issue(5'd15, 3, 0, 0, 0);
    issue(5'd16, 0, 0, 0, 0);

    // Illegal opcode leaves registers alone
    issue(5'd31, 1, 2, 3, 8'hAA);
    for (int i = 0; i < NR; i++) issue(5'd15, 2'(i), 0, 0, 0);

    // op_valid held through a multiply: the follow-on LD waits for ready
    acc0 = n_acc;
    issue(5'd1, 0, 0, 1, 8'h03);
    acc0 = n_acc;
    drive(5'd13, 0, 1, 2, 0);
    wait_ready(t);
    @(posedge clk);
    model(5'd13, 0, 1, 2, 0);
    @(negedge clk);
    drive(5'd1, 0, 0, 3, 8'h5A);
    wait_ready(t);
    check("held busy cycles", t, W + 1);
    check("held accepts during busy", n_acc - acc0, 1);
    check("held mul flags", {bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_e}, {m_z, m_c, m_n, m_e});
    @(posedge clk);
    model(5'd1, 0, 0, 3, 8'h5A);
    @(negedge clk);
    bus.op_valid = 1'b0;
    check("held accepts total", n_acc - acc0, 2);
    issue(5'd15, 2, 0, 0, 0);
    issue(5'd15, 3, 0, 0, 0);
    issue(5'd16, 0, 0, 0, 0);

    // Random mix, illegal opcodes included
    for (int i = 0; i < 40; i++)
      issue(5'($urandom_range(0, 20)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    for (int i = 0; i < NR; i++) issue(5'd15, 2'(i), 0, 0, 0);

    // Asynchronous reset in the middle of a multiply
    issue(5'd1, 0, 0, 0, 8'h33);
    issue(5'd1, 0, 0, 1, 8'h05);
    issue(5'd15, 0, 0, 0, 0);
    drive(5'd13, 0, 1, 2, 0);
    wait_ready(t);
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset out_data", bus.out_data, 0);
    check("midreset out_valid", {31'b0, bus.out_valid}, 0);
    check("midreset flags", {bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_e}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("ready after midreset", {31'b0, bus.op_ready}, 1);
    @(negedge clk);
    issue(5'd15, 2, 0, 0, 0);
    issue(5'd1, 0, 0, 2, 8'h9C);
    issue(5'd15, 2, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU with an NREGS-entry register file, flag register and a valid/ready op interface. Single-cycle ops (load, move, add/sub, shifts, logic, compare, output) complete in one clock. Iterative multiply and divide run a DATA_W-cycle state machine with back-pressure. It replaces the fixed 8-bit A/B/Acc datapath in the microcontroller core and is driven by the control unit one op at a time.

## Interface
- DATA_W, 8, datapath width; legal range 4..32
- NREGS, 4, register-file depth; power of two, at least 2; RW = log2(NREGS)
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- OpValid  in  1  op request
- OpReady  out  1  ALU can accept an op; equals (state == IDLE)
- Op  in  5  opcode: 0 NOP, 1 LD, 2 MOV, 3 ADD, 4 SUB, 5 SHL, 6 SHR, 7 AND, 8 OR, 9 XOR, 10 CMPE, 11 CMPL, 12 CMPG, 13 MUL, 14 DIV, 15 OE, 16 OEHI; 17..31 illegal
- SrcA, SrcB, Dst  in  RW each  register indices
- InData  in  DATA_W  immediate for LD
- OutData  out  DATA_W  registered output data; holds its last value
- OutValid  out  1  one-cycle pulse; OutData is new in that cycle
- FlagZ, FlagC, FlagN, FlagE  out  1 each  status flags

## Operation
- Accept: an op is accepted on a rising edge with OpValid && OpReady. A = R[SrcA] and B = R[SrcB] are sampled at accept.
- LD: R[Dst] = InData.
- MOV: R[Dst] = A.
- Flags unchanged for NOP, LD, MOV, OE and OEHI.
- ADD: R[Dst] = A + B mod 2^DATA_W. C = carry out.
- SUB: R[Dst] = A - B mod 2^DATA_W. C = borrow (A < B unsigned).
- SHL, SHR: R[Dst] = A shifted by 1 with zero fill. C = the bit shifted out.
- AND, OR, XOR: R[Dst] = A op B. C = 0.
- For ADD, SUB, SHL, SHR, AND, OR, XOR:
  - Z = (result == 0); N = result MSB.
  - E is cleared.
- CMPE, CMPL, CMPG: Z = (A == B), (A < B) and (A > B) respectively, all unsigned. No register write; C, N and E unchanged.
- MUL: unsigned shift-add over DATA_W iterations.
  - R[Dst] = product low half; internal Hi register = product high half.
  - Z = (full 2·DATA_W product == 0); C = (Hi != 0); N = low-half MSB; E = 0.
- DIV: unsigned restoring division over DATA_W iterations.
  - R[Dst] = quotient; Hi = remainder.
  - Z = (quotient == 0); C = 0; N = 0; E = 0.
- DIV with B == 0: no iteration; completes as a single-cycle op.
  - R[Dst] = all ones; Hi = A.
  - E = 1; Z = C = N = 0.
- OE: OutData = A, OutValid = 1.
- OEHI: OutData = Hi, OutValid = 1.
- Illegal opcode: E = 1; no register, Hi or other flag change; no OutValid.
- State machine:
  - IDLE: accepts ops. MUL with any B, or DIV with B != 0, goes to BUSY with counter = DATA_W-1. All other ops execute and stay in IDLE.
  - BUSY: one iteration per cycle; counter decrements; at counter == 0 go to DONE. OpValid is ignored.
  - DONE: write R[Dst], Hi and flags; go to IDLE.
- Dst and the operands are latched at accept, so a multi-cycle op cannot be disturbed by its inputs changing.
- Reset (any time, including during BUSY/DONE):
  - All R[], Hi, OutData and every flag go to 0; OutValid = 0; state = IDLE.
  - An in-flight op is dropped with no write.
  - OpReady = 1 once Rst deasserts.

## Timing
- Single-cycle ops: register, Hi and flag updates happen at the accepting edge and are visible the next cycle. Back-to-back ops every cycle are supported, with full read-after-write forwarding through the register file.
- OE/OEHI: OutData and OutValid are registered at the accepting edge; OutValid is high for exactly that following cycle.
- MUL and DIV (B != 0):
  - OpReady is low for exactly DATA_W+1 cycles after the accepting edge (DATA_W BUSY cycles plus 1 DONE cycle).
  - The result is written at the DONE edge.
  - OpReady returns high in the cycle after that edge, and a new op may be accepted then.
- OpReady has no combinational dependence on OpValid.

## Test plan
- Single-cycle ALU (DATA_W=8, NREGS=4): LD R0=0xF0, LD R1=0x20, ADD R2=R0+R1 → R2=0x10, C=1, Z=0, N=0, E=0.
- SUB: R0=0x05, R1=0x07, SUB into R3 → R3=0xFE, C=1, N=1. Then CMPL R0,R1 → Z=1, C and N unchanged.
- MUL 0x0F × 0x11:
  - OpReady low exactly 9 cycles; R[Dst]=0xFF; C=0.
  - Then OEHI → OutData=0x00 with a one-cycle OutValid.
  - 0xFF × 0xFF → low half 0x01, Hi=0xFE, C=1.
- DIV:
  - 0x64 / 0x07 → quotient 0x0E, OEHI gives remainder 0x02, 9-cycle busy window.
  - 0x64 / 0x00 → R[Dst]=0xFF, Hi=0x64, E=1, OpReady never drops.
- Illegal and held ops: opcode 0x1F → E=1, registers unchanged. OpValid held high during MUL → no op is accepted until OpReady rises; exactly one op is accepted per handshake.
- Reset mid-MUL: assert Rst in BUSY cycle 4 → all outputs 0 immediately (asynchronous), R[Dst] not written, OpReady=1 after release, and a following LD works.
